// File: rtl/mux_addr_scanner.sv
// Channel address scanner for a 5-to-1 display multiplexor: auto dwell scan or manual stepping.
// Optional blanking cycle after each address change when SCAN_BLANK_EN is defined.
module mux_addr_scanner #(
    parameter int DWELL = 1000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       step,
    output logic [2:0] addr,
    output logic [4:0] dig_en,
    output logic       frame
);

    localparam int                CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DWELL - 1);

    generate
        if (DWELL < 1 || DWELL > 1048576) begin : g_bad_dwell
            $error("mux_addr_scanner: DWELL must be in 1..1048576");
        end
`ifdef SCAN_BLANK_EN
        // A one-cycle dwell with blanking would keep every channel dark.
        if (DWELL < 2) begin : g_bad_blank_dwell
            $error("mux_addr_scanner: DWELL must be at least 2 with SCAN_BLANK_EN");
        end
`endif
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_addr;
    logic [4:0]       r_dig_en;
    logic             r_frame;

    logic             w_wrap;
    logic             w_adv;
    logic [2:0]       w_addr_nxt;
    logic [4:0]       w_onehot;
    logic [4:0]       w_dig_nxt;

    assign w_wrap = (r_cnt == CNT_MAX);
    // Manual step only counts while the auto scan is disabled.
    assign w_adv  = en ? w_wrap : step;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_addr_nxt = r_addr;
        if (r_addr > 3'd4) begin
            w_addr_nxt = 3'd0;
        end else if (w_adv) begin
            w_addr_nxt = (r_addr == 3'd4) ? 3'd0 : r_addr + 3'd1;
        end
    end

    always_comb begin
        w_onehot = 5'b00001;
        case (r_addr)
            3'd0:    w_onehot = 5'b00001;
            3'd1:    w_onehot = 5'b00010;
            3'd2:    w_onehot = 5'b00100;
            3'd3:    w_onehot = 5'b01000;
            3'd4:    w_onehot = 5'b10000;
            default: w_onehot = 5'b00001;
        endcase
    end

`ifdef SCAN_BLANK_EN
    assign w_dig_nxt = w_adv ? 5'b00000 : w_onehot;
`else
    assign w_dig_nxt = w_onehot;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt    <= '0;
            r_addr   <= 3'd0;
            r_dig_en <= 5'b00000;
            r_frame  <= 1'b0;
        end else begin
            if (en) begin
                r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            end else if (step) begin
                r_cnt <= '0;
            end
            r_addr   <= w_addr_nxt;
            r_dig_en <= w_dig_nxt;
            r_frame  <= w_adv && (r_addr == 3'd4);
        end
    end

    assign addr   = r_addr;
    assign dig_en = r_dig_en;
    assign frame  = r_frame;

endmodule

// File: tb/tb_mux_addr_scanner.sv
// Self-checking bench for mux_addr_scanner: directed tables and sequences plus a randomized
// run against a position/tick reference model, over DWELL = 4, 3 and (unblanked builds) 1.
module tb_mux_addr_scanner;

    logic clk = 1'b0;
    logic clr;
    logic en;
    logic step;

    always #5 clk = ~clk;

`ifdef SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
    localparam int NI    = 2;
`else
    localparam bit BLANK = 1'b0;
    localparam int NI    = 3;
`endif

    localparam int DW [3] = '{4, 3, 1};

    logic [2:0] w_addr  [3];
    logic [4:0] w_dig   [3];
    logic       w_frame [3];

    mux_addr_scanner #(.DWELL(4)) u_d4 (
        .clk(clk), .clr(clr), .en(en), .step(step),
        .addr(w_addr[0]), .dig_en(w_dig[0]), .frame(w_frame[0])
    );

    mux_addr_scanner #(.DWELL(3)) u_d3 (
        .clk(clk), .clr(clr), .en(en), .step(step),
        .addr(w_addr[1]), .dig_en(w_dig[1]), .frame(w_frame[1])
    );

`ifndef SCAN_BLANK_EN
    mux_addr_scanner #(.DWELL(1)) u_d1 (
        .clk(clk), .clr(clr), .en(en), .step(step),
        .addr(w_addr[2]), .dig_en(w_dig[2]), .frame(w_frame[2])
    );
`else
    assign w_addr[2]  = 3'd0;
    assign w_dig[2]   = 5'd0;
    assign w_frame[2] = 1'b0;
`endif

    // Reference model: ticks spent at the current position and the scan position itself.
    int m_cnt   [3];
    int m_pos   [3];
    int m_dig   [3];
    int m_frame [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         en;
        bit         step;
        logic [2:0] addr;
        logic [4:0] dig;
        bit         frame;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]   = 0;
            m_pos[k]   = 0;
            m_dig[k]   = 0;
            m_frame[k] = 0;
        end
    endtask

    task automatic model_edge(input bit e, input bit s);
        bit adv;
        for (int k = 0; k < 3; k++) begin
            adv = 1'b0;
            if (e) begin
                m_cnt[k]++;
                if (m_cnt[k] == DW[k]) begin
                    m_cnt[k] = 0;
                    adv      = 1'b1;
                end
            end else if (s) begin
                m_cnt[k] = 0;
                adv      = 1'b1;
            end
            m_dig[k]   = (BLANK && adv) ? 0 : (1 << m_pos[k]);
            m_frame[k] = (adv && m_pos[k] == 4) ? 1 : 0;
            if (adv) m_pos[k] = (m_pos[k] + 1) % 5;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s addr[%0d]", tag, k), 32'(w_addr[k]), m_pos[k]);
            check($sformatf("%s dig_en[%0d]", tag, k), 32'(w_dig[k]), m_dig[k]);
            check($sformatf("%s frame[%0d]", tag, k), 32'(w_frame[k]), m_frame[k]);
        end
    endtask

    task automatic cycle(input bit e, input bit s, input string tag);
        en   = e;
        step = s;
        @(posedge clk);
        model_edge(e, s);
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without an edge.
    task automatic pulse_reset();
        #3;
        clr = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        clr = 1'b1;
    endtask

    initial begin
        clr  = 1'b0;
        en   = 1'b0;
        step = 1'b0;
        model_reset();

        for (int i = 0; i < 25; i++) begin
            vecs[i].en    = 1'b1;
            vecs[i].step  = 1'b0;
            vecs[i].addr  = 3'(((i + 1) / 4) % 5);
            vecs[i].frame = (i + 1 == 20);
            vecs[i].dig   = (BLANK && ((i + 1) % 4 == 0)) ? 5'b00000 : 5'(1 << ((i / 4) % 5));
        end

        #12;
        check_all("reset");
        clr = 1'b1;

        // Auto scan from release, DWELL=4.
        for (int i = 0; i < 25; i++) begin
            cycle(vecs[i].en, vecs[i].step, "auto");
            check($sformatf("tbl addr e%0d", i + 1), 32'(w_addr[0]), 32'(vecs[i].addr));
            check($sformatf("tbl dig e%0d", i + 1), 32'(w_dig[0]), 32'(vecs[i].dig));
            check($sformatf("tbl frame e%0d", i + 1), 32'(w_frame[0]), 32'(vecs[i].frame));
        end

        // Freeze mid-dwell, then resume from the frozen count.
        pulse_reset();
        cycle(1'b1, 1'b0, "frz");
        cycle(1'b1, 1'b0, "frz");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, "frz");
            check("frozen addr", 32'(w_addr[0]), 32'd0);
        end
        cycle(1'b1, 1'b0, "resume");
        check("resume e1 addr", 32'(w_addr[0]), 32'd0);
        cycle(1'b1, 1'b0, "resume");
        check("resume e2 addr", 32'(w_addr[0]), 32'd1);

        // Manual stepping across the wrap, then confirm the count was cleared.
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, "step");
            check($sformatf("step%0d addr", i + 1), 32'(w_addr[0]), 32'((i + 1) % 5));
            check($sformatf("step%0d frame", i + 1), 32'(w_frame[0]), 32'(i == 4));
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, "post_step");
            check("post_step hold", 32'(w_addr[0]), 32'd1);
        end
        cycle(1'b1, 1'b0, "post_step");
        check("post_step adv", 32'(w_addr[0]), 32'd2);

        // Step held with en=1 has no effect, DWELL=3.
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b1, "en_step");
            check($sformatf("en_step e%0d", i + 1), 32'(w_addr[1]), 32'((i + 1) / 3));
        end

        // Asynchronous reset with addr=3, cnt=2 on the DWELL=4 scanner.
        pulse_reset();
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, "pre_rst");
        check("pre_rst addr", 32'(w_addr[0]), 32'd3);
        pulse_reset();
        cycle(1'b0, 1'b0, "post_rst");
        check("post_rst dig_en", 32'(w_dig[0]), 32'b00001);

        // Randomized run with occasional mid-scan resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) pulse_reset();
            cycle(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_addr_scanner.md
MUX_ADDR_SCANNER -- requirements
Module: mux_addr_scanner

Interface
REQ-001 Parameter DWELL, default 1000, is the number of clk cycles each channel address is held in auto mode; legal range 1..1048576.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clr  input  1  reset; asynchronous, active-low.
REQ-004 en  input  1  auto-scan enable; 1 = advance every DWELL cycles, 0 = scan frozen or manual stepping.
REQ-005 step  input  1  manual advance request, sampled each rising edge; honoured only while en=0.
REQ-006 addr  output  3  registered channel address for the downstream 5-to-1 multiplexor select; values 0..4 only.
REQ-007 dig_en  output  5  registered one-hot channel enable, aligned with the multiplexor's registered output.
REQ-008 frame  output  1  registered one-cycle pulse marking completion of a full 0..4 scan.

Function
REQ-009 Dwell counter cnt SHALL be ceil(log2(DWELL)) bits, minimum 1 bit, and count 0..DWELL-1.
REQ-010 en=1: cnt SHALL increment each edge; at cnt==DWELL-1, cnt SHALL return to 0 and addr SHALL advance on the same edge.
REQ-011 Address sequence SHALL be 0,1,2,3,4,0,...; after 4 the next value is 0.
REQ-012 addr values 5..7 SHALL never be driven; any such internal value SHALL load 0 on the next edge.
REQ-013 DWELL=1: addr SHALL advance on every edge while en=1.
REQ-014 en=0: cnt and addr SHALL hold, except as given by REQ-015.
REQ-015 en=0 and step=1 at an edge: addr SHALL advance by one position and cnt SHALL clear to 0; step held high advances once per edge.
REQ-016 en=1 and step=1 together: step SHALL be ignored.
REQ-017 en deasserted mid-dwell: cnt SHALL freeze; on re-assertion, counting SHALL resume from the frozen value.
REQ-018 frame SHALL be 1 for exactly the one cycle in which addr has just changed from 4 to 0, by either auto or manual advance; otherwise 0.
REQ-019 dig_en SHALL load onehot(addr) on every edge, giving one cycle of latency from addr, matching the registered multiplexor output latency; bit i set means channel i.
REQ-020 dig_en SHALL have exactly one bit set at all times after the first post-reset edge, except as given by REQ-024.

Reset
REQ-021 clr=0 SHALL immediately force addr=0, cnt=0, dig_en=5'b00000 and frame=0, independent of clk.
REQ-022 Reset asserted mid-dwell or mid-frame SHALL abandon the scan; no frame pulse SHALL be produced by the reset.
REQ-023 After clr rises, the first edge SHALL load dig_en=5'b00001; with en=1, the first addr advance occurs DWELL edges after release.

Configuration
REQ-024 Macro SCAN_BLANK_EN defined: for the one cycle following each addr change, dig_en SHALL load 5'b00000 instead of onehot(addr); the one-hot value loads on the next edge. This suppresses display ghosting.
REQ-025 SCAN_BLANK_EN defined: DWELL SHALL be at least 2, and elaboration SHALL fail otherwise.
REQ-026 SCAN_BLANK_EN undefined: no blanking cycle is inserted, and REQ-019 applies unconditionally.

Verification
REQ-027 DWELL=4, en=1 from reset release, 25 edges -> addr 0,1,2,3,4,0 changing every 4 edges; frame is high for one cycle at edge 20; dig_en follows addr by one cycle.
REQ-028 DWELL=4, en=1 for 2 edges, en=0 for 10 edges, en=1 -> addr stays 0 while frozen; it advances to 1 exactly 2 edges after re-enable.
REQ-029 en=0, step pulsed high for 6 consecutive edges -> addr 1,2,3,4,0,1; frame is high for one cycle after the 5th step; cnt=0 throughout.
REQ-030 en=1 and step=1 held, DWELL=3 -> addr advances only every 3 edges; step has no effect.
REQ-031 clr pulsed low asynchronously mid-cycle with addr=3 and cnt=2 -> outputs go to 0 without waiting for an edge; after release, dig_en=5'b00001 on the first edge.
REQ-032 SCAN_BLANK_EN defined, DWELL=3 -> dig_en sequence is 00001,00001,00000,00010,00010,00000,00100,...
